// File: rtl/exp_pkg.sv
// Shared definitions for the exponent pipeline: result width, frame depth
// and the result collector's state encoding.
package exp_pkg;

    localparam int EXP_DATA_W      = 16;
    localparam int EXP_FRAME_DEPTH = 8;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } collector_state_e;

endpackage

// File: rtl/exp_result_collector.sv
// Collects one frame of exponent results, accumulates the softmax denominator
// and then replays the frame in arrival order over a valid/ready port.
module exp_result_collector
    import exp_pkg::*;
#(
    parameter int  DATA_W = EXP_DATA_W,
    parameter int  DEPTH  = EXP_FRAME_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int SUM_W  = DATA_W + PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    output logic              in_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [SUM_W-1:0]  sum,
    output logic              sum_valid,
    output logic              frame_done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow_err
);

    collector_state_e  state_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [SUM_W-1:0]  sum_r;
    logic              sum_valid_r;
    logic              frame_done_r;
    logic              overflow_err_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic accept_s;
    logic xfer_s;

    assign accept_s = exp_valid & (state_r == COLLECT);
    assign xfer_s   = rd_ready  & (state_r == DRAIN);

    assign in_ready     = (state_r == COLLECT);
    assign rd_valid     = (state_r == DRAIN);
    assign rd_data      = rd_valid ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign sum          = sum_r;
    assign sum_valid    = sum_valid_r;
    assign frame_done   = frame_done_r;
    assign count        = count_r;
    assign overflow_err = overflow_err_r;

    // Frame storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s && !clear) begin
            mem_r[wr_ptr_r] <= exp_data;
        end
    end

    // Collect/drain sequencing, pointers, running sum and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= COLLECT;
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= {CNT_W{1'b0}};
            sum_r          <= {SUM_W{1'b0}};
            sum_valid_r    <= 1'b0;
            frame_done_r   <= 1'b0;
            overflow_err_r <= 1'b0;
        end else if (clear) begin
            state_r        <= COLLECT;
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= {CNT_W{1'b0}};
            sum_r          <= {SUM_W{1'b0}};
            sum_valid_r    <= 1'b0;
            frame_done_r   <= 1'b0;
            overflow_err_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            // A result offered while draining is lost; flag it until cleared.
            if (exp_valid && (state_r != COLLECT)) begin
                overflow_err_r <= 1'b1;
            end
            case (state_r)
                COLLECT: begin
                    if (accept_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                        count_r  <= count_r + CNT_W'(1);
                        sum_r    <= sum_r + SUM_W'(exp_data);
                        if (count_r == CNT_W'(DEPTH - 1)) begin
                            state_r      <= DRAIN;
                            sum_valid_r  <= 1'b1;
                            frame_done_r <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer_s) begin
                        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                        count_r  <= count_r - CNT_W'(1);
                        if (count_r == CNT_W'(1)) begin
                            state_r     <= COLLECT;
                            wr_ptr_r    <= {PTR_W{1'b0}};
                            rd_ptr_r    <= {PTR_W{1'b0}};
                            sum_r       <= {SUM_W{1'b0}};
                            sum_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_result_collector.sv
// Randomized and directed bench for exp_result_collector against a
// queue-based frame model.
module tb_exp_result_collector;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        in_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic [18:0] sum;
    logic        sum_valid;
    logic        frame_done;
    logic [3:0]  count;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame as a list, a read index and two flags.
    int unsigned m_frame[$];
    int          m_rd;
    bit          m_drain;
    bit          m_ovf;
    bit          m_fd;

    exp_result_collector dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .exp_valid    (exp_valid),
        .exp_data     (exp_data),
        .in_ready     (in_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .sum          (sum),
        .sum_valid    (sum_valid),
        .frame_done   (frame_done),
        .count        (count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int unsigned model_sum();
        int unsigned s = 0;
        foreach (m_frame[i]) s += m_frame[i];
        return s;
    endfunction

    function automatic void model_reset();
        m_frame.delete();
        m_rd    = 0;
        m_drain = 1'b0;
        m_ovf   = 1'b0;
        m_fd    = 1'b0;
    endfunction

    function automatic void model_step(input bit ev, input int unsigned ed, input bit rr, input bit clr);
        m_fd = 1'b0;
        if (clr) begin
            model_reset();
        end else if (!m_drain) begin
            if (ev) begin
                m_frame.push_back(ed);
                if (m_frame.size() == 8) begin
                    m_drain = 1'b1;
                    m_fd    = 1'b1;
                    m_rd    = 0;
                end
            end
        end else begin
            if (ev) m_ovf = 1'b1;
            if (rr) begin
                m_rd++;
                if (m_rd == 8) begin
                    m_drain = 1'b0;
                    m_frame.delete();
                    m_rd = 0;
                end
            end
        end
    endfunction

    task automatic check_all();
        check_val("in_ready",   32'(in_ready),     32'(!m_drain));
        check_val("rd_valid",   32'(rd_valid),     32'(m_drain));
        check_val("sum_valid",  32'(sum_valid),    32'(m_drain));
        check_val("frame_done", 32'(frame_done),   32'(m_fd));
        check_val("count",      32'(count),        m_drain ? 32'(8 - m_rd) : 32'(m_frame.size()));
        check_val("sum",        32'(sum),          model_sum());
        check_val("overflow",   32'(overflow_err), 32'(m_ovf));
        if (m_drain) check_val("rd_data", 32'(rd_data), m_frame[m_rd]);
    endtask

    task automatic cycle(input bit ev, input logic [15:0] ed, input bit rr, input bit clr);
        exp_valid = ev;
        exp_data  = ed;
        rd_ready  = rr;
        clear     = clr;
        @(posedge clk);
        model_step(ev, 32'(ed), rr, clr);
        @(negedge clk);
        exp_valid = 1'b0;
        rd_ready  = 1'b0;
        clear     = 1'b0;
        check_all();
    endtask

    // Eight pulses separated by idle cycles.
    task automatic fill(input logic [15:0] vals [8]);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vals[i], 1'b0, 1'b0);
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic scenario_ramp(input string tag);
        logic [15:0] v [8];
        for (int i = 0; i < 8; i++) v[i] = 16'((i + 1) * 32'h1000);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, v[i], 1'b0, 1'b0);
            if (i == 7) check_val({tag, "_fd"}, 32'(frame_done), 32'd1);
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
        end
        check_val({tag, "_sum"}, 32'(sum), 32'h24000);
        check_val({tag, "_sv"},  32'(sum_valid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_val({tag, "_rd"}, 32'(rd_data), 32'((i + 1) * 32'h1000));
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        check_val({tag, "_inr"}, 32'(in_ready), 32'd1);
        check_val({tag, "_sum0"}, 32'(sum), 32'd0);
        check_val({tag, "_cnt0"}, 32'(count), 32'd0);
    endtask

    initial begin
        logic [15:0] v [8];
        logic [15:0] got [$];
        bit          pat [4];
        int          k;

        reset = 1'b0; clear = 1'b0; exp_valid = 1'b0; exp_data = 16'h0; rd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        check_val("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b1;

        // 1: ramp frame
        scenario_ramp("s1");

        // 2: saturating values must not wrap the sum
        for (int i = 0; i < 8; i++) v[i] = 16'hFFFF;
        fill(v);
        check_val("s2_sum", 32'(sum), 32'h7FFF8);
        drain_all();

        // 3: stalled reads hold data; every value delivered once in order
        for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
        fill(v);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        got.delete();
        k = 0;
        while (m_drain && k < 64) begin
            if (pat[k % 4] && rd_valid) got.push_back(rd_data);
            cycle(1'b0, 16'h0, pat[k % 4], 1'b0);
            k++;
        end
        check_val("s3_ndeliv", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++) check_val("s3_order", 32'(got[i]), 32'(v[i]));

        // 4: overflow while draining
        for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
        fill(v);
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        check_val("s4_ovf", 32'(overflow_err), 32'd1);
        drain_all();
        for (int i = 0; i < 8; i++) v[i] = 16'(32'h100 * (i + 1));
        fill(v);
        check_val("s4_sum", 32'(sum), 32'h2400);
        check_val("s4_ovf_sticky", 32'(overflow_err), 32'd1);
        drain_all();

        // 5: clear wins over a simultaneous accept
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h2000, 1'b0, 1'b0);
        check_val("s5_sum3", 32'(sum), 32'h6000);
        cycle(1'b1, 16'h4000, 1'b0, 1'b1);
        check_val("s5_cnt", 32'(count), 32'd0);
        check_val("s5_sum", 32'(sum), 32'd0);
        check_val("s5_ovf", 32'(overflow_err), 32'd0);
        for (int i = 0; i < 8; i++) v[i] = 16'(i + 1);
        fill(v);
        check_val("s5_first", 32'(rd_data), 32'd1);
        drain_all();

        // 6: asynchronous reset mid-drain
        for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
        fill(v);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("s6_rd_valid", 32'(rd_valid), 32'd0);
        check_val("s6_in_ready", 32'(in_ready), 32'd1);
        check_val("s6_sum",      32'(sum), 32'd0);
        check_val("s6_count",    32'(count), 32'd0);
        check_val("s6_rd_data",  32'(rd_data), 32'd0);
        @(negedge clk);
        check_all();
        reset = 1'b1;
        scenario_ramp("s6");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 9) < 4), 16'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_result_collector.md
Name: exp_result_collector

Overview:
Downstream stage of the serial exponent unit.
- Captures each 16-bit exponent result as it completes.
- Buffers one frame of DEPTH results and keeps their running sum, which serves as the softmax denominator.
- Once the frame is full, streams the stored results out in arrival order through a valid/ready port for the normalising divider.

Parameters:
DATA_W, 16, width of one exponent result (matches exponent out[15:0])
DEPTH, 8, results per frame; power of two, 2..64
SUM_W, DATA_W+$clog2(DEPTH), accumulator width; derived, never overridden; cannot overflow

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous frame abort; returns to COLLECT
exp_valid  input  1  one-cycle pulse: exp_data holds a finished exponent result
exp_data  input  DATA_W  exponent result
in_ready  output  1  high when a result can be accepted; upstream starts no new exponent while low
rd_valid  output  1  stored result available
rd_data  output  DATA_W  stored result at read pointer
rd_ready  input  1  consumer accepts rd_data
sum  output  SUM_W  sum of all results of current frame
sum_valid  output  1  sum is final (frame complete)
frame_done  output  1  one-cycle pulse when frame becomes complete
count  output  $clog2(DEPTH)+1  results held in current frame
overflow_err  output  1  sticky: exp_valid arrived while in_ready low

Behaviour:
- Reset (asynchronous, active-low) drives the following:
  - state=COLLECT; wr_ptr=rd_ptr=0, count=0, sum=0.
  - sum_valid=0, frame_done=0, rd_valid=0, overflow_err=0, in_ready=1.
  - rd_data=0; storage contents are don't-care.
- States: COLLECT, DRAIN (2-state FSM, registered state).
- COLLECT:
  - in_ready=1, rd_valid=0.
  - On exp_valid: mem[wr_ptr]<=exp_data, wr_ptr++, count++, sum<=sum+exp_data (zero-extended, unsigned).
  - When the accepted value is the DEPTH-th: next cycle state=DRAIN, sum_valid=1, frame_done=1 for exactly one cycle, count=DEPTH.
  - Latency: last accept to rd_valid/sum_valid is 1 cycle.
- DRAIN:
  - in_ready=0, rd_valid=1, rd_data=mem[rd_ptr] (combinational read of the register array).
  - Handshake: on rd_valid&rd_ready, rd_ptr++ and count--.
  - After the DEPTH-th transfer, the next cycle is: state=COLLECT, wr_ptr=rd_ptr=0, sum=0, sum_valid=0.
  - sum stays stable and valid throughout DRAIN.
- exp_valid while in_ready=0: data dropped, state unchanged, overflow_err<=1. overflow_err is cleared only by reset or clear.
- clear:
  - Highest priority over any simultaneous accept or read.
  - Next cycle matches post-reset values except storage; overflow_err is cleared.
- rd_ready held low in DRAIN: rd_data and rd_valid hold indefinitely; no timeout.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH; count is one bit wider so it can reach DEPTH.
- exp_valid and rd_ready can never both be effective in the same cycle, because the FSM separates them.

Decomposition:
- Shared package exp_pkg:
  - EXP_DATA_W=16 and EXP_FRAME_DEPTH=8 constants.
  - collector state enum {COLLECT, DRAIN}.
  - Shared with serial_exponent and the divider.
- Single module; storage is an inline register array. No sub-module is warranted.

Test Plan:
1. Reset, then feed exp_data 0x1000,0x2000,...,0x8000 on 8 separate pulses. Required: frame_done pulses once 1 cycle after the 8th; sum=0x24000; sum_valid=1. With rd_ready=1, read order is 0x1000..0x8000 on 8 consecutive cycles; then in_ready=1, sum=0, count=0.
2. 8 pulses of 0xFFFF. Required: sum=0x7FFF8 with no wrap; all reads return 0xFFFF.
3. Fill a frame, then toggle rd_ready 1,0,0,1,... Required: rd_data holds while rd_ready=0; all 8 values are delivered exactly once, in order.
4. In DRAIN, pulse exp_valid with 0x1234. Required: overflow_err=1 and stays 1; drained values are unaffected; the next frame's sum excludes 0x1234.
5. After 3 accepts (sum=0x6000), assert clear in the same cycle as exp_valid=0x4000. Required: next cycle count=0, sum=0, overflow_err=0, and 0x4000 is not stored.
6. Drive reset low asynchronously, between clock edges, in the middle of DRAIN. Required: outputs go immediately to their reset values; after release, a fresh 8-value frame behaves as in scenario 1.
